// File: rtl/sdram_bist_pkg.sv
// Shared types and constants for the SDRAM BIST sequencer.
package sdram_bist_pkg;

  typedef enum logic [1:0] {
    ModeConst = 2'd0,
    ModeAddr  = 2'd1,
    ModeLfsr  = 2'd2,
    ModeWalk  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrWait,
    StRdReq,
    StRdWait,
    StDone
  } state_e;

  localparam logic [7:0]  LfsrTap8  = 8'hB8;
  localparam logic [15:0] LfsrTap16 = 16'hB400;
  localparam logic [31:0] LfsrTap32 = 32'hA3000000;

  // Galois tap mask for the supported data widths.
  function automatic logic [31:0] lfsr_tap(input int unsigned width);
    case (width)
      8:       return {24'h0, LfsrTap8};
      16:      return {16'h0, LfsrTap16};
      default: return LfsrTap32;
    endcase
  endfunction

endpackage

// File: rtl/sdram_bist_patgen.sv
// Test pattern generator shared by the write and read passes.
// load restarts the sequence; advance steps it to the next word.
module sdram_bist_patgen
  import sdram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W        = 15,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned IDX_W         = 9,
  parameter logic [31:0] CONST_PATTERN = 32'hAAAA,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  mode_e             mode,
  input  logic [IDX_W-1:0]  index,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] pattern
);

  localparam logic [DATA_W-1:0] Seed = DATA_W'(LFSR_SEED);
  localparam logic [DATA_W-1:0] Tap  = DATA_W'(lfsr_tap(DATA_W));
  localparam logic [DATA_W-1:0] One  = DATA_W'(1);

  logic [DATA_W-1:0] lfsr_q, lfsr_d;

  // LFSR next state: reload wins over advance.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = Seed;
    end else if (advance) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ Tap) : (lfsr_q >> 1);
    end
  end

  // LFSR register, holds the seed out of reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) lfsr_q <= Seed;
    else         lfsr_q <= lfsr_d;
  end

  // Current pattern word for the selected mode.
  always_comb begin
    pattern = DATA_W'(CONST_PATTERN);
    unique case (mode)
      ModeConst: pattern = DATA_W'(CONST_PATTERN);
      ModeAddr:  pattern = DATA_W'(addr);
      ModeLfsr:  pattern = lfsr_q;
      ModeWalk:  pattern = One << (32'(index) % DATA_W);
    endcase
  end

endmodule

// File: rtl/sdram_bist.sv
// SDRAM BIST sequencer: full write pass then full read/compare pass over a
// configurable window. Optional watchdog enabled by SDRAM_BIST_TIMEOUT_EN.
module sdram_bist
  import sdram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned START_ADDR     = 0,
  parameter int unsigned NUM_WORDS      = 512,
  parameter logic [31:0] CONST_PATTERN  = 32'hAAAA,
  parameter logic [31:0] LFSR_SEED      = 32'hACE1,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [15:0]       o_err_count,
  output logic [ADDR_W-1:0] o_first_fail_addr,
  output logic [DATA_W-1:0] o_first_fail_data,
  output logic [7:0]        o_status,
  output logic              o_sdram_en,
  output logic              o_rw,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  input  logic              i_ready,
  input  logic              i_dataval,
  input  logic [DATA_W-1:0] i_rdata
);

  if (NUM_WORDS < 1) begin : g_bad_num_words
    $error("NUM_WORDS must be at least 1");
  end
  if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) begin : g_bad_data_w
    $error("DATA_W must be 8, 16 or 32");
  end
  if (LFSR_SEED[DATA_W-1:0] == '0) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WORDS - 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] ffa_q, ffa_d;
  logic [DATA_W-1:0] ffd_q, ffd_d;
  logic              busy_q, busy_d, done_q, done_d;
  // Registered compare result, folded into the error state one edge later.
  logic              cmp_vld_q, cmp_vld_d, cmp_fail_q, cmp_fail_d, cmp_last_q, cmp_last_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [DATA_W-1:0] cmp_data_q, cmp_data_d;

  logic              req_en, req_rw, pat_load, pat_adv, last, timeout;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] pattern;

`ifdef SDRAM_BIST_TIMEOUT_EN
  logic [31:0] wait_q, wait_d;
  logic        timeout_q, timeout_d;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Window wraps modulo the address space.
  assign addr = ADDR_W'(START_ADDR + 32'(idx_q));
  assign last = (idx_q == LastIdx);

  sdram_bist_patgen #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .IDX_W        (IdxW),
    .CONST_PATTERN(CONST_PATTERN),
    .LFSR_SEED    (LFSR_SEED)
  ) u_patgen (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .mode   (mode_q),
    .index  (idx_q),
    .addr   (addr),
    .load   (pat_load),
    .advance(pat_adv),
    .pattern(pattern)
  );

  // Next-state, datapath updates and request outputs.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    err_d      = err_q;
    ffa_d      = ffa_q;
    ffd_d      = ffd_q;
    busy_d     = busy_q;
    done_d     = done_q;
    cmp_vld_d  = 1'b0;
    cmp_fail_d = 1'b0;
    cmp_last_d = 1'b0;
    cmp_addr_d = cmp_addr_q;
    cmp_data_d = cmp_data_q;
    req_en     = 1'b0;
    req_rw     = 1'b0;
    pat_load   = 1'b0;
    pat_adv    = 1'b0;
`ifdef SDRAM_BIST_TIMEOUT_EN
    timeout_d  = timeout_q;
    wait_d     = '0;
`endif

    if (cmp_vld_q) begin
      if (cmp_fail_q) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (err_q == 16'd0) begin
          ffa_d = cmp_addr_q;
          ffd_d = cmp_data_q;
        end
      end
      if (cmp_last_q) begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        // busy_q still high for one cycle after the final read lands.
        if (i_start && !busy_q) begin
          mode_d   = mode_e'(i_mode);
          idx_d    = '0;
          err_d    = '0;
          ffa_d    = '0;
          ffd_d    = '0;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          pat_load = 1'b1;
          state_d  = StWrReq;
`ifdef SDRAM_BIST_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      StWrReq: begin
        req_en = 1'b1;
        if (i_ready) state_d = StWrWait;
      end
      StWrWait: begin
        if (i_ready) begin
          if (last) begin
            idx_d    = '0;
            pat_load = 1'b1;
            state_d  = StRdReq;
          end else begin
            idx_d   = idx_q + 1'b1;
            pat_adv = 1'b1;
            state_d = StWrReq;
          end
        end
      end
      StRdReq: begin
        req_en = 1'b1;
        req_rw = 1'b1;
        if (i_ready) state_d = StRdWait;
      end
      StRdWait: begin
        if (i_dataval) begin
          cmp_vld_d  = 1'b1;
          cmp_fail_d = (i_rdata != pattern);
          cmp_last_d = last;
          cmp_addr_d = addr;
          cmp_data_d = i_rdata;
          if (last) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            pat_adv = 1'b1;
            state_d = StRdReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef SDRAM_BIST_TIMEOUT_EN
    // Counts cycles spent in one active state; any transition restarts it.
    if (busy_q && state_q != StIdle && state_q != StDone && state_d == state_q) begin
      wait_d = wait_q + 32'd1;
      if (wait_q == TIMEOUT_CYCLES - 1) begin
        timeout_d = 1'b1;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = StDone;
        wait_d    = '0;
      end
    end
`endif
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= StIdle;
      mode_q     <= ModeConst;
      idx_q      <= '0;
      err_q      <= '0;
      ffa_q      <= '0;
      ffd_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cmp_vld_q  <= 1'b0;
      cmp_fail_q <= 1'b0;
      cmp_last_q <= 1'b0;
      cmp_addr_q <= '0;
      cmp_data_q <= '0;
`ifdef SDRAM_BIST_TIMEOUT_EN
      wait_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      ffa_q      <= ffa_d;
      ffd_q      <= ffd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_fail_q <= cmp_fail_d;
      cmp_last_q <= cmp_last_d;
      cmp_addr_q <= cmp_addr_d;
      cmp_data_q <= cmp_data_d;
`ifdef SDRAM_BIST_TIMEOUT_EN
      wait_q     <= wait_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_pass            = done_q && (err_q == 16'd0) && !timeout;
  assign o_timeout         = timeout;
  assign o_err_count       = err_q;
  assign o_first_fail_addr = ffa_q;
  assign o_first_fail_data = ffd_q;
  assign o_status          = {o_done, o_pass, o_timeout, o_busy, 2'b00, mode_q};
  assign o_sdram_en        = req_en;
  assign o_rw              = req_rw;
  // Address and data are zero whenever no request is presented.
  assign o_addr            = req_en ? addr : '0;
  assign o_wdata           = (req_en && !req_rw) ? pattern : '0;

endmodule

// File: tb/tb_sdram_bist.sv
// Self-checking bench for sdram_bist: default-window instance plus a wrapping
// 32-word instance, each driven by a fixed-latency controller model.
module tb_sdram_bist;

  typedef struct packed {
    logic        rw;
    logic [14:0] addr;
    logic [15:0] data;
  } req_t;

  typedef struct {
    logic [1:0]  mode;
    bit          flip_en;
    logic [14:0] flip_addr;
    logic [15:0] exp_err;
    logic [14:0] exp_ffa;
    logic [15:0] exp_ffd;
    bit          exp_pass;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  // Instance A: default parameters.
  logic        st_a, rdy_a, dv_a;
  logic [1:0]  mode_a;
  logic        busy_a, done_a, pass_a, tmo_a, en_a, rw_a;
  logic [15:0] err_a, wdata_a, rdata_a, ffd_a;
  logic [14:0] ffa_a, addr_a;
  logic [7:0]  status_a;

  // Instance B: 32-word window wrapping past the top of the address space.
  logic        st_b, rdy_b, dv_b;
  logic [1:0]  mode_b;
  logic        busy_b, done_b, pass_b, tmo_b, en_b, rw_b;
  logic [15:0] err_b, wdata_b, rdata_b, ffd_b;
  logic [14:0] ffa_b, addr_b;
  logic [7:0]  status_b;

  sdram_bist dut_a (
    .i_clk(clk), .i_rstn(rstn), .i_start(st_a), .i_mode(mode_a),
    .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a), .o_timeout(tmo_a),
    .o_err_count(err_a), .o_first_fail_addr(ffa_a), .o_first_fail_data(ffd_a),
    .o_status(status_a), .o_sdram_en(en_a), .o_rw(rw_a), .o_addr(addr_a),
    .o_wdata(wdata_a), .i_ready(rdy_a), .i_dataval(dv_a), .i_rdata(rdata_a)
  );

  sdram_bist #(.START_ADDR(32'h7FF0), .NUM_WORDS(32)) dut_b (
    .i_clk(clk), .i_rstn(rstn), .i_start(st_b), .i_mode(mode_b),
    .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b), .o_timeout(tmo_b),
    .o_err_count(err_b), .o_first_fail_addr(ffa_b), .o_first_fail_data(ffd_b),
    .o_status(status_b), .o_sdram_en(en_b), .o_rw(rw_b), .o_addr(addr_b),
    .o_wdata(wdata_b), .i_ready(rdy_b), .i_dataval(dv_b), .i_rdata(rdata_b)
  );

  // Controller models: write on acceptance, read data returned two edges later.
  logic [15:0] mem_a [0:32767];
  logic [15:0] mem_b [0:32767];
  logic        p1v_a, p2v_a, p1v_b, p2v_b;
  logic [14:0] p1a_a, p2a_a, p1a_b, p2a_b;
  bit          flip_en;
  logic [14:0] flip_addr;

  always @(posedge clk) begin
    if (!rstn) begin
      p1v_a <= 1'b0; p2v_a <= 1'b0; p1v_b <= 1'b0; p2v_b <= 1'b0;
    end else begin
      if (en_a && rdy_a && !rw_a) mem_a[addr_a] <= wdata_a;
      p1v_a <= en_a && rdy_a && rw_a;
      p1a_a <= addr_a;
      p2v_a <= p1v_a;
      p2a_a <= p1a_a;
      if (en_b && rdy_b && !rw_b) mem_b[addr_b] <= wdata_b;
      p1v_b <= en_b && rdy_b && rw_b;
      p1a_b <= addr_b;
      p2v_b <= p1v_b;
      p2a_b <= p1a_b;
    end
  end

  assign dv_a    = p2v_a;
  assign rdata_a = mem_a[p2a_a] ^ {15'h0, (flip_en && p2a_a == flip_addr)};
  assign dv_b    = p2v_b;
  assign rdata_b = mem_b[p2a_b];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Scoreboards: expected requests queued at start, popped on each acceptance.
  req_t        qa[$];
  req_t        qb[$];
  int          wseen_a, wseen_b;
  logic [15:0] first_w [3];

  always @(negedge clk) begin
    req_t e;
    if (rstn && en_a && rdy_a) begin
      if (qa.size() == 0) begin
        chk("req_a_unexpected", {rw_a, addr_a}, 64'hFFFF_FFFF);
      end else begin
        e = qa.pop_front();
        chk("req_a", {rw_a, addr_a, rw_a ? 16'h0 : wdata_a}, {e.rw, e.addr, e.rw ? 16'h0 : e.data});
      end
      if (!rw_a) begin
        if (wseen_a < 3) first_w[wseen_a] = wdata_a;
        wseen_a++;
      end
    end
    if (rstn && en_b && rdy_b) begin
      if (qb.size() == 0) begin
        chk("req_b_unexpected", {rw_b, addr_b}, 64'hFFFF_FFFF);
      end else begin
        e = qb.pop_front();
        chk("req_b", {rw_b, addr_b, rw_b ? 16'h0 : wdata_b}, {e.rw, e.addr, e.rw ? 16'h0 : e.data});
      end
      if (!rw_b) wseen_b++;
    end
  end

  task automatic push_a(input logic [1:0] m);
    logic [15:0] lf, d;
    lf = 16'hACE1;
    for (int i = 0; i < 512; i++) begin
      case (m)
        2'd0:    d = 16'hAAAA;
        2'd1:    d = 16'(i);
        2'd2:    d = lf;
        default: d = 16'h1 << (i % 16);
      endcase
      qa.push_back('{rw: 1'b0, addr: 15'(i), data: d});
      lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
    end
    for (int i = 0; i < 512; i++) qa.push_back('{rw: 1'b1, addr: 15'(i), data: 16'h0});
  endtask

  task automatic run_start_a(input logic [1:0] m);
    push_a(m);
    wseen_a = 0;
    mode_a  = m;
    st_a    = 1'b1;
    @(posedge clk); #1;
    st_a = 1'b0;
    chk("busy_after_start", busy_a, 1);
    chk("en_after_start", en_a, 1);
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (!done_a && n < 10000) begin @(posedge clk); #1; n++; end
    chk("done_a", done_a, 1);
  endtask

  vec_t vecs [5];

  initial begin
    int n;
    logic [14:0] saved;
    vecs[0] = '{2'd0, 1'b0, 15'd0,  16'd0, 15'd0,  16'h0000, 1'b1};
    vecs[1] = '{2'd1, 1'b1, 15'd37, 16'd1, 15'd37, 16'h0024, 1'b0};
    vecs[2] = '{2'd2, 1'b0, 15'd0,  16'd0, 15'd0,  16'h0000, 1'b1};
    vecs[3] = '{2'd3, 1'b0, 15'd0,  16'd0, 15'd0,  16'h0000, 1'b1};
    vecs[4] = '{2'd0, 1'b1, 15'd0,  16'd1, 15'd0,  16'hAAAB, 1'b0};

    rstn = 1'b0; st_a = 1'b0; st_b = 1'b0; mode_a = 2'd0; mode_b = 2'd0;
    rdy_a = 1'b1; rdy_b = 1'b1; flip_en = 1'b0; flip_addr = '0;
    wseen_a = 0; wseen_b = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs_a", {busy_a, done_a, pass_a, tmo_a, en_a, rw_a, addr_a, wdata_a}, 0);
    chk("rst_err_a", {err_a, ffa_a, ffd_a, status_a}, 0);
    chk("rst_outputs_b", {busy_b, done_b, en_b, addr_b, wdata_b, status_b}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Table-driven full runs on instance A.
    for (int v = 0; v < 5; v++) begin
      flip_en   = vecs[v].flip_en;
      flip_addr = vecs[v].flip_addr;
      run_start_a(vecs[v].mode);
      wait_done_a();
      chk("busy_end", busy_a, 0);
      chk("err_count", err_a, vecs[v].exp_err);
      chk("first_fail_addr", ffa_a, vecs[v].exp_ffa);
      chk("first_fail_data", ffd_a, vecs[v].exp_ffd);
      chk("pass", pass_a, vecs[v].exp_pass);
      chk("status", status_a, {1'b1, vecs[v].exp_pass, 1'b0, 1'b0, 2'b00, vecs[v].mode});
      chk("sb_a_empty", qa.size(), 0);
      if (vecs[v].mode == 2'd2) begin
        chk("lfsr_w0", first_w[0], 16'hACE1);
        chk("lfsr_w1", first_w[1], 16'hE270);
        chk("lfsr_w2", first_w[2], 16'h7138);
      end
    end

    // Error on the last word: count and done land one edge after the data.
    flip_en = 1'b1; flip_addr = 15'd511;
    run_start_a(2'd3);
    n = 0;
    while (!(dv_a && p2a_a == 15'd511) && n < 10000) begin @(posedge clk); #1; n++; end
    chk("last_read_seen", dv_a, 1);
    @(posedge clk); #1;
    chk("last_edge_done", {done_a, busy_a}, 2'b01);
    chk("last_edge_err", err_a, 0);
    @(posedge clk); #1;
    chk("after_edge_done", {done_a, busy_a, pass_a}, 3'b100);
    chk("after_edge_err", {err_a, ffa_a, ffd_a}, {16'd1, 15'd511, 16'h8001});
    flip_en = 1'b0;

    // Controller stall: request held stable while not ready.
    run_start_a(2'd0);
    n = 0;
    while (!(en_a && !rw_a && addr_a == 15'd5) && n < 1000) begin @(posedge clk); #1; n++; end
    rdy_a = 1'b0;
    saved = addr_a;
    repeat (50) @(posedge clk);
    #1;
    chk("stall_hold", {en_a, rw_a, busy_a, tmo_a, addr_a}, {1'b1, 1'b0, 1'b1, 1'b0, saved});
    rdy_a = 1'b1;
    wait_done_a();
    chk("stall_pass", pass_a, 1);
    chk("sb_a_empty_stall", qa.size(), 0);

    // Reset mid-run during the write of index 100, then restart from index 0.
    run_start_a(2'd1);
    n = 0;
    while (!(en_a && !rw_a && addr_a == 15'd100) && n < 1000) begin @(posedge clk); #1; n++; end
    chk("reached_idx100", addr_a, 100);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrun_rst_outputs", {busy_a, done_a, pass_a, tmo_a, en_a, rw_a, addr_a, wdata_a}, 0);
    chk("midrun_rst_err", {err_a, ffa_a, ffd_a, status_a}, 0);
    qa.delete();
    rstn = 1'b1;
    @(posedge clk); #1;
    run_start_a(2'd1);
    wait_done_a();
    chk("restart_pass", {pass_a, err_a}, {1'b1, 16'd0});
    chk("sb_a_empty_restart", qa.size(), 0);

    // Instance B: wrapping window, walking one, ignored second start.
    for (int i = 0; i < 32; i++)
      qb.push_back('{rw: 1'b0, addr: 15'(32'h7FF0 + i), data: 16'h1 << (i % 16)});
    for (int i = 0; i < 32; i++)
      qb.push_back('{rw: 1'b1, addr: 15'(32'h7FF0 + i), data: 16'h0});
    wseen_b = 0;
    mode_b  = 2'd3;
    st_b    = 1'b1;
    @(posedge clk); #1;
    st_b = 1'b0;
    chk("b_busy_after_start", {busy_b, en_b, addr_b}, {1'b1, 1'b1, 15'h7FF0});
    n = 0;
    while (wseen_b < 10 && n < 1000) begin @(posedge clk); #1; n++; end
    mode_b = 2'd0;
    st_b   = 1'b1;
    @(posedge clk); #1;
    st_b = 1'b0;
    n = 0;
    while (!done_b && n < 2000) begin @(posedge clk); #1; n++; end
    chk("b_done", {done_b, busy_b, pass_b}, 3'b101);
    chk("b_err", err_b, 0);
    chk("b_status", status_b, 8'hC3);
    chk("sb_b_empty", qb.size(), 0);

`ifdef SDRAM_BIST_TIMEOUT_EN
    // Never-ready controller: watchdog fires after 4096 cycles in WR_REQ.
    rdy_a  = 1'b0;
    mode_a = 2'd0;
    st_a   = 1'b1;
    @(posedge clk); #1;
    st_a = 1'b0;
    repeat (4095) @(posedge clk);
    #1;
    chk("tmo_not_yet", {tmo_a, done_a, en_a}, 3'b001);
    @(posedge clk); #1;
    chk("tmo_fired", {tmo_a, done_a, pass_a, en_a, busy_a}, 5'b11000);
    rdy_a = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
